// File: rtl/read_operation_pkg.sv
// Shared FIFO helpers: Gray/binary conversion and the default depth constant.
package read_operation_pkg;

    localparam int FIFO_SIZE  = 4;
    localparam int FIFO_DEPTH = 1 << FIFO_SIZE;

    // Generic 32-bit versions; callers zero-extend narrower pointers and slice.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/read_operation_sync_w2r.sv
// Two-flop synchroniser bringing the Gray write pointer into the read clock domain.
module sync_w2r #(
    parameter int WIDTH = 5
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/read_operation.sv
// Async-FIFO read side: read pointer, Gray rptr, registered empty flag.
// Optional RD_LEVEL_EN adds the registered rlevel occupancy output.
module read_operation
    import read_operation_pkg::*;
#(
    parameter int SIZE = FIFO_SIZE
) (
    input  logic            rclk,
    input  logic            rrst,
    input  logic [SIZE:0]   wptr,
    input  logic            rinc,
    output logic            rempty,
    output logic [SIZE-1:0] raddr,
    output logic [SIZE:0]   rptr
`ifdef RD_LEVEL_EN
    ,
    output logic [SIZE:0]   rlevel
`endif
);

    logic [SIZE:0] rq2_wptr;
    logic [SIZE:0] rbin_q, rbin_d;
    logic [SIZE:0] rptr_q, rgray_d;
    logic          rempty_q;
    logic [31:0]   rgray_w;
    logic          unused_gray;

    sync_w2r #(.WIDTH(SIZE + 1)) u_sync (
        .rclk (rclk),
        .rrst (rrst),
        .d    (wptr),
        .q    (rq2_wptr)
    );

    assign rbin_d      = rbin_q + {{SIZE{1'b0}}, (rinc & ~rempty_q)};
    assign rgray_w     = bin2gray(32'(rbin_d));
    assign rgray_d     = rgray_w[SIZE:0];
    assign unused_gray = ^rgray_w[31:SIZE+1];

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin_q   <= '0;
            rptr_q   <= '0;
            rempty_q <= 1'b1;
        end else begin
            rbin_q   <= rbin_d;
            rptr_q   <= rgray_d;
            rempty_q <= (rgray_d == rq2_wptr);
        end
    end

    assign raddr  = rbin_q[SIZE-1:0];
    assign rptr   = rptr_q;
    assign rempty = rempty_q;

`ifdef RD_LEVEL_EN
    logic [31:0]   wbin_w;
    logic [SIZE:0] wbin_sync;
    logic [SIZE:0] rlevel_q;
    logic          unused_wbin;

    assign wbin_w      = gray2bin(32'(rq2_wptr));
    assign wbin_sync   = wbin_w[SIZE:0];
    assign unused_wbin = ^wbin_w[31:SIZE+1];

    // Occupancy after this edge's read, modulo the pointer range.
    always_ff @(posedge rclk) begin
        if (rrst) rlevel_q <= '0;
        else      rlevel_q <= wbin_sync - rbin_d;
    end

    assign rlevel = rlevel_q;
`endif

endmodule

// File: tb/tb_read_operation.sv
// Bench for read_operation (SIZE=4): cycle model + directed literal checks.
module tb_read_operation;

    localparam int SIZE = 4;

    logic            rclk = 1'b0;
    logic            rrst = 1'b1;
    logic [SIZE:0]   wptr = '0;
    logic            rinc = 1'b0;
    logic            rempty;
    logic [SIZE-1:0] raddr;
    logic [SIZE:0]   rptr;
`ifdef RD_LEVEL_EN
    logic [SIZE:0]   rlevel;
`endif

    read_operation #(.SIZE(SIZE)) dut (
        .rclk   (rclk),
        .rrst   (rrst),
        .wptr   (wptr),
        .rinc   (rinc),
        .rempty (rempty),
        .raddr  (raddr),
        .rptr   (rptr)
`ifdef RD_LEVEL_EN
        ,
        .rlevel (rlevel)
`endif
    );

    always #5 rclk = ~rclk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [4:0] g2b(input logic [4:0] g);
        logic [4:0] b;
        for (int i = 0; i < 5; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    function automatic logic [4:0] b2g(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    // Model: words read so far, write count as seen two edges late.
    int   m_reads;
    int   m_level;
    bit   m_empty;
    bit   m_valid = 0;
    logic [4:0] m_s1, m_s2;
    int   accepted = 0;

    always @(posedge rclk) begin
        int wcnt;
        if (rrst) begin
            m_reads = 0; m_empty = 1; m_level = 0; m_s1 = 0; m_s2 = 0;
            m_valid = 1;
        end else if (m_valid) begin
            if (rinc && !m_empty) begin
                m_reads = (m_reads + 1) % 32;
                accepted++;
            end
            wcnt    = int'(g2b(m_s2));
            m_empty = (wcnt == m_reads);
            m_level = (wcnt - m_reads + 32) % 32;
            m_s2    = m_s1;
            m_s1    = wptr;
        end
    end

    logic [4:0] prev_rptr = '0;
    bit         wrap_seen = 0;

    always @(posedge rclk) begin
        #1;
        if (m_valid) begin
            check("rempty", int'(rempty), int'(m_empty));
            check("raddr",  int'(raddr),  m_reads % 16);
            check("rptr",   int'(rptr),   int'(b2g(m_reads)));
`ifdef RD_LEVEL_EN
            check("rlevel", int'(rlevel), m_level);
`endif
            check("rptr_onebit", int'($countones(rptr ^ prev_rptr) <= 1), 1);
            if (prev_rptr == 5'b10000 && rptr == 5'b00000) wrap_seen = 1;
            prev_rptr = rptr;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge rclk);
    endtask

    initial begin
        int base;
        // Reset held two cycles with rinc high.
        @(negedge rclk);
        rrst = 1; rinc = 1; wptr = '0;
        tick(2);
        check("rst_rempty", int'(rempty), 1);
        check("rst_rptr",   int'(rptr),   0);
        check("rst_raddr",  int'(raddr),  0);
`ifdef RD_LEVEL_EN
        check("rst_rlevel", int'(rlevel), 0);
`endif
        // One word written: empty drops on the third edge.
        rrst = 0; rinc = 0; wptr = 5'b00001;
        tick(2);
        check("sync_edge2_empty", int'(rempty), 1);
        tick(1);
        check("sync_edge3_empty", int'(rempty), 0);
        check("sync_raddr",       int'(raddr),  0);
        // Single read of the only word.
        rinc = 1;
        tick(1);
        rinc = 0;
        check("read1_raddr",  int'(raddr),  1);
        check("read1_rptr",   int'(rptr),   1);
        check("read1_rempty", int'(rempty), 1);
        // Reads while empty are ignored.
        rinc = 1;
        tick(5);
        check("empty_raddr",  int'(raddr),  1);
        check("empty_rptr",   int'(rptr),   1);
        check("empty_rempty", int'(rempty), 1);
        // Wrap: writer steps through 31 and back to 1, reader reads continuously.
        base = accepted;
        for (int w = 2; w <= 33; w++) begin
            wptr = b2g(w % 32);
            tick(1);
        end
        tick(8);
        rinc = 0;
        check("wrap_words",  accepted - base, 32);
        check("wrap_seen",   int'(wrap_seen), 1);
        check("wrap_raddr",  int'(raddr),  1);
        check("wrap_rptr",   int'(rptr),   1);
        check("wrap_rempty", int'(rempty), 1);
        // Level and mid-read reset.
        rrst = 1; tick(1); rrst = 0;
        wptr = 5'b01111;
        tick(3);
        check("lvl_empty", int'(rempty), 0);
`ifdef RD_LEVEL_EN
        check("lvl10", int'(rlevel), 10);
`endif
        rinc = 1;
        tick(1);
        check("lvl_raddr", int'(raddr), 1);
`ifdef RD_LEVEL_EN
        check("lvl9", int'(rlevel), 9);
`endif
        rrst = 1;
        tick(1);
        check("midrst_raddr",  int'(raddr),  0);
        check("midrst_rptr",   int'(rptr),   0);
        check("midrst_rempty", int'(rempty), 1);
`ifdef RD_LEVEL_EN
        check("midrst_rlevel", int'(rlevel), 0);
`endif
        rrst = 0; rinc = 0;
        tick(3);
        check("resume_empty", int'(rempty), 0);
        rinc = 1;
        tick(2);
        rinc = 0;
        check("resume_raddr", int'(raddr), 2);
        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/read_operation.md
READ_OPERATION -- requirements
Module: read_operation

Interface
REQ-001 SHALL have parameter SIZE, default 4, meaning address width; FIFO depth 2**SIZE, pointers SIZE+1 bits.
REQ-002 SHALL have port rclk  input  1  read-domain clock; all state updates on rising edge.
REQ-003 SHALL have port rrst  input  1  reset, synchronous, active-high (one clock; polarity and synchronicity fixed).
REQ-004 SHALL have port wptr  input  SIZE+1  Gray-coded write pointer from the write domain, asynchronous to rclk.
REQ-005 SHALL have port rinc  input  1  read request; one word consumed per cycle when accepted.
REQ-006 SHALL have port rempty  output  1  registered FIFO-empty flag.
REQ-007 SHALL have port raddr  output  SIZE  memory read address.
REQ-008 SHALL have port rptr  output  SIZE+1  registered Gray-coded read pointer sent to the write domain.
REQ-009 SHALL have port rlevel  output  SIZE+1  registered occupancy as seen by the reader; present only with RD_LEVEL_EN.

Function
REQ-010 SHALL synchronise wptr into rclk through exactly two flops to give rq2_wptr; no logic between the flops.
REQ-011 SHALL hold a binary read pointer rbin of SIZE+1 bits; rbin_next = rbin + (rinc & ~rempty), modulo 2**(SIZE+1).
REQ-012 SHALL drive raddr = rbin[SIZE-1:0], combinationally from the register.
REQ-013 SHALL compute rgray_next = (rbin_next >> 1) ^ rbin_next and register it into rptr every rclk edge.
REQ-014 SHALL register rempty <= (rgray_next == rq2_wptr) every rclk edge.
REQ-015 SHALL ignore rinc while rempty=1: rbin, rptr and raddr unchanged.
REQ-016 SHALL accept a read in the cycle rempty=0 and rinc=1; raddr advances by 1 on that edge.
REQ-017 SHALL wrap rbin from 2**(SIZE+1)-1 to 0 without a stall, and rptr from Gray(max) to 0.
REQ-018 SHALL assert rempty on the same edge where the last available word is read (rgray_next matches rq2_wptr).
REQ-019 SHALL deassert rempty on the 3rd rclk edge after wptr changes and stays stable (2 sync edges + 1 flag edge).
REQ-020 SHALL change rptr by at most one bit per rclk edge.

Reset
REQ-021 SHALL, with rrst=1 at a rclk edge, set rbin=0, rptr=0, both synchroniser flops=0, rempty=1, rlevel=0.
REQ-022 SHALL, on reset asserted mid-read, discard the read on that edge; reset wins over rinc.
REQ-023 SHALL resume normal operation on the first rclk edge with rrst=0.

Configuration
REQ-024 SHALL, with RD_LEVEL_EN defined, convert rq2_wptr Gray to binary and register rlevel <= wbin_sync - rbin_next (mod 2**(SIZE+1)), range 0..2**SIZE.
REQ-025 SHALL, without RD_LEVEL_EN, omit the rlevel port and the Gray-to-binary logic; all other behaviour identical.

Structure
REQ-026 SHALL obtain Gray-to-binary and binary-to-Gray functions and the depth constant from the shared FIFO package.
REQ-027 SHALL implement the two-flop synchroniser as sub-module sync_w2r (parameter WIDTH=SIZE+1; ports rclk, rrst, d, q).

Verification (SIZE=4)
REQ-028 SHALL cover: rrst=1 for 2 cycles with rinc=1 -> rempty=1, rptr=5'b00000, raddr=0, rlevel=0.
REQ-029 SHALL cover: wptr=5'b00001 held, rinc=0 -> rempty falls on 3rd rclk edge; raddr=0.
REQ-030 SHALL cover: wptr=5'b00001, one rinc pulse after rempty=0 -> raddr=1, rptr=5'b00001, rempty=1 on that edge.
REQ-031 SHALL cover: rinc=1 for 5 cycles while empty -> rptr, raddr, rempty unchanged.
REQ-032 SHALL cover wrap: wptr stepped Gray through 31 then 0, continuous reads -> raddr 15->0 and rptr 5'b10000->5'b00000 with no missed word.
REQ-033 SHALL cover, with RD_LEVEL_EN: wptr=5'b01111 (bin 10) -> rlevel=10 after sync; one read -> rlevel=9; rrst mid-stream -> rlevel=0.
